btn_debouncer_bank: RTL
=======================

Name: btn_debouncer_bank

Overview:
Multi-channel successor to the single-input button debouncer. Debounces NUM_BTNS asynchronous button inputs with a shared tick prescaler, and produces per-channel debounced levels plus one-cycle press, release, long-press and auto-repeat event pulses. Sits between board pins and the UI/game-control logic, so consumers no longer need their own edge detectors.

Parameters:
NUM_BTNS, 4, number of independent button channels (1..16)
CLKIN_FREQ, 27_000_000, clk frequency in Hz
TICK_US, 100, sample-tick period in microseconds; TICK_CYCLES = CLKIN_FREQ*TICK_US/1_000_000, must be >= 1
DEBOUNCE_TICKS, 10, consecutive ticks of changed input required before the level flips (1 ms default)
HOLD_TICKS, 5000, ticks held pressed before btn_long fires (500 ms default)
REPEAT_TICKS, 1000, auto-repeat period in ticks after long press; 0 disables repeat
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (inverted after synchroniser)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_in  input  NUM_BTNS  raw asynchronous button pins
btn_level  output  NUM_BTNS  debounced level, 1 = pressed
btn_press  output  NUM_BTNS  1-cycle pulse on debounced press
btn_release  output  NUM_BTNS  1-cycle pulse on debounced release
btn_long  output  NUM_BTNS  1-cycle pulse when held HOLD_TICKS
btn_repeat  output  NUM_BTNS  1-cycle pulse every REPEAT_TICKS after btn_long while held
any_press  output  1  OR of btn_press, same cycle

Behaviour:
- Reset: all outputs 0; synchronisers load the inactive pin level (1 if ACTIVE_LOW); prescaler, all counters cleared; channels in RELEASED.
- Synchroniser: 2-FF per channel, then optional inversion -> s[i] (1 = pressed). Input-to-s latency 2 cycles.
- Prescaler: shared counter 0..TICK_CYCLES-1; tick asserted for 1 cycle when counter = TICK_CYCLES-1, then wraps to 0. TICK_CYCLES = 1 -> tick every cycle.
- Stability counter per channel (width clog2(DEBOUNCE_TICKS+1)): any cycle with s[i] == btn_level[i] clears it (cleared immediately, not only on tick). On tick with s[i] != btn_level[i], increments; when the increment reaches DEBOUNCE_TICKS, btn_level flips on the next clock edge, counter clears, and btn_press or btn_release pulses on that same edge (registered, visible for exactly one cycle).
- Glitch shorter than one tick with no tick sampling it: no effect. Any bounce back to old level restarts the count from 0.
- Per-channel FSM: RELEASED -> PRESSED on debounced press; PRESSED -> LONG when hold count reaches HOLD_TICKS (btn_long pulse); LONG -> LONG with btn_repeat pulse each REPEAT_TICKS ticks (if nonzero); PRESSED/LONG -> RELEASED on debounced release (btn_release pulse; hold and repeat counters cleared, no long/repeat that cycle).
- Hold counter: counts ticks in PRESSED starting at 0 on the press edge; saturates, never wraps. Repeat counter: counts ticks in LONG, reloads 0 on each btn_repeat.
- Simultaneous: channels fully independent; several channels may pulse in the same cycle. Release debounced on the same tick a long/repeat would fire -> release wins, long/repeat suppressed.
- Reset mid-press: all state cleared; a still-held button re-debounces and produces a fresh btn_press.
- Width rules: counter widths from clog2 of their limits; HOLD_TICKS >= 1 required; DEBOUNCE_TICKS >= 1.

Decomposition:
- Shared constants include: state encodings RELEASED/PRESSED/LONG (2-bit), helper for TICK_CYCLES computation.
- Top holds prescaler and any_press; one sub-module btn_channel (synchroniser, stability counter, FSM, hold/repeat counters) instantiated NUM_BTNS times via generate, all sharing tick.

Test Plan:
(Bench params: CLKIN_FREQ=1_000_000, TICK_US=4 -> TICK_CYCLES=4, DEBOUNCE_TICKS=3, HOLD_TICKS=10, REPEAT_TICKS=4, NUM_BTNS=4, ACTIVE_LOW=1.)
- Reset, pins all 1 for 100 cycles -> all outputs 0, no pulses.
- btn_in[0] driven 0 and held -> btn_level[0] rises 9..14 cycles after the edge (3 ticks + sync); btn_press[0] and any_press high exactly 1 cycle; other channels silent.
- btn_in[1] toggled every 5 cycles for 60 cycles, then held 0 -> no press during bouncing; exactly one btn_press[1] after the final stable 3 ticks.
- Hold btn_in[0] 0 for 80 ticks -> btn_long[0] at 10 ticks after press, then btn_repeat[0] every 16 cycles; release -> single btn_release[0], no further repeats.
- Press channels 2 and 3 in the same cycle -> btn_press[2] and btn_press[3] in the same cycle, any_press one cycle.
- Assert reset while channel 0 in LONG, pin still 0 -> outputs 0 during reset; after release of reset, fresh btn_press[0] after debounce, btn_long again after 10 ticks.

Source files
------------

// File: rtl/btn_debouncer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_debouncer_bank_pkg
// Purpose  : Shared state encodings and sizing helpers for the debouncer bank.
// Revision : 1.0 - initial release
// ============================================================================
package btn_debouncer_bank_pkg;

    localparam logic [1:0] c_stReleased = 2'd0;
    localparam logic [1:0] c_stPressed  = 2'd1;
    localparam logic [1:0] c_stLong     = 2'd2;

    // 64-bit intermediate: the default 27 MHz * 100 us product overflows int.
    function automatic int tickCycles(input longint clkHz, input longint tickUs);
        return int'((clkHz * tickUs) / 64'd1_000_000);
    endfunction

    function automatic int cntWidth(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debouncer_bank_btn_channel.sv
`default_nettype none
// ============================================================================
// Module   : btn_channel
// Purpose  : One debounced button: synchroniser, stability counter and
//            press/long/repeat state machine driven by a shared sample tick.
// Revision : 1.0 - initial release
// ============================================================================
module btn_channel
    import btn_debouncer_bank_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int HOLD_TICKS     = 5000,
    parameter int REPEAT_TICKS   = 1000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btnIn,
    output logic btnLevel,
    output logic btnPress,
    output logic btnRelease,
    output logic btnLong,
    output logic btnRepeat
);

    localparam int c_dbW      = cntWidth(DEBOUNCE_TICKS);
    localparam int c_holdW    = cntWidth(HOLD_TICKS);
    localparam int c_repW     = cntWidth(REPEAT_TICKS);
    localparam bit c_repeatOn = (REPEAT_TICKS > 0);

    localparam logic [c_dbW-1:0]   c_dbLast   = c_dbW'(DEBOUNCE_TICKS - 1);
    localparam logic [c_holdW-1:0] c_holdLast = c_holdW'(HOLD_TICKS - 1);
    localparam logic [c_holdW-1:0] c_holdMax  = c_holdW'(HOLD_TICKS);
    localparam logic [c_repW-1:0]  c_repLast  = c_repW'(c_repeatOn ? REPEAT_TICKS - 1 : 0);

    logic               r_syncMeta;
    logic               r_syncPin;
    logic               w_sampled;
    logic               r_level;
    logic [c_dbW-1:0]   r_dbCount;
    logic               w_differs;
    logic               w_flip;
    logic               w_pressEvt;
    logic               w_releaseEvt;

    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;
    logic [c_holdW-1:0] r_holdCount;
    logic [c_repW-1:0]  r_repCount;
    logic               w_holdDue;
    logic               w_repeatDue;
    logic               w_longEvt;
    logic               w_repeatEvt;

    logic               r_press;
    logic               r_release;
    logic               r_long;
    logic               r_repeat;

    // Synchronisers idle at the unpressed pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_syncMeta <= ACTIVE_LOW;
            r_syncPin  <= ACTIVE_LOW;
        end else begin
            r_syncMeta <= btnIn;
            r_syncPin  <= r_syncMeta;
        end
    end

    assign w_sampled    = r_syncPin ^ ACTIVE_LOW;
    assign w_differs    = (w_sampled != r_level);
    assign w_flip       = tick && w_differs && (r_dbCount == c_dbLast);
    assign w_pressEvt   = w_flip && !r_level;
    assign w_releaseEvt = w_flip && r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level   <= 1'b0;
            r_dbCount <= '0;
        end else if (!w_differs) begin
            r_dbCount <= '0;
        end else if (tick) begin
            if (r_dbCount == c_dbLast) begin
                r_level   <= ~r_level;
                r_dbCount <= '0;
            end else begin
                r_dbCount <= r_dbCount + c_dbW'(1);
            end
        end
    end

    assign w_holdDue   = tick && (r_holdCount == c_holdLast);
    assign w_repeatDue = c_repeatOn && tick && (r_repCount == c_repLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_stReleased;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_stReleased: begin
                if (w_pressEvt) w_stateNext = c_stPressed;
            end
            c_stPressed: begin
                if (w_releaseEvt)   w_stateNext = c_stReleased;
                else if (w_holdDue) w_stateNext = c_stLong;
            end
            c_stLong: begin
                if (w_releaseEvt) w_stateNext = c_stReleased;
            end
            default: w_stateNext = c_stReleased;
        endcase
    end

    // A release debounced on the same tick masks any long/repeat event.
    always_comb begin
        w_longEvt   = 1'b0;
        w_repeatEvt = 1'b0;
        case (r_state)
            c_stPressed: w_longEvt   = w_holdDue && !w_releaseEvt;
            c_stLong:    w_repeatEvt = w_repeatDue && !w_releaseEvt;
            default: begin
                w_longEvt   = 1'b0;
                w_repeatEvt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_releaseEvt || (r_state == c_stReleased)) begin
            r_holdCount <= '0;
            r_repCount  <= '0;
        end else if (tick) begin
            if ((r_state == c_stPressed) && (r_holdCount != c_holdMax)) begin
                r_holdCount <= r_holdCount + c_holdW'(1);
            end
            if ((r_state == c_stLong) && c_repeatOn) begin
                r_repCount <= w_repeatDue ? '0 : r_repCount + c_repW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_press   <= w_pressEvt;
            r_release <= w_releaseEvt;
            r_long    <= w_longEvt;
            r_repeat  <= w_repeatEvt;
        end
    end

    assign btnLevel   = r_level;
    assign btnPress   = r_press;
    assign btnRelease = r_release;
    assign btnLong    = r_long;
    assign btnRepeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/btn_debouncer_bank.sv
`default_nettype none
// ============================================================================
// Module   : btn_debouncer_bank
// Purpose  : NUM_BTNS button debouncers sharing one sample-tick prescaler,
//            with per-channel level and press/release/long/repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debouncer_bank
    import btn_debouncer_bank_pkg::*;
#(
    parameter int NUM_BTNS       = 4,
    parameter int CLKIN_FREQ     = 27_000_000,
    parameter int TICK_US        = 100,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int HOLD_TICKS     = 5000,
    parameter int REPEAT_TICKS   = 1000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_long,
    output logic [NUM_BTNS-1:0] btn_repeat,
    output logic                any_press
);

    localparam int c_tickCycles = tickCycles(CLKIN_FREQ, TICK_US);
    localparam int c_prescW     = cntWidth(c_tickCycles - 1);
    localparam logic [c_prescW-1:0] c_prescLast = c_prescW'(c_tickCycles - 1);

    logic [c_prescW-1:0] r_prescale;
    logic                w_tick;

    // With one cycle per tick the counter stays at zero and tick is constant high.
    assign w_tick = (r_prescale == c_prescLast);

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + c_prescW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
            btn_channel #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .HOLD_TICKS     (HOLD_TICKS),
                .REPEAT_TICKS   (REPEAT_TICKS),
                .ACTIVE_LOW     (ACTIVE_LOW)
            ) u_chan (
                .clk        (clk),
                .reset      (reset),
                .tick       (w_tick),
                .btnIn      (btn_in[gi]),
                .btnLevel   (btn_level[gi]),
                .btnPress   (btn_press[gi]),
                .btnRelease (btn_release[gi]),
                .btnLong    (btn_long[gi]),
                .btnRepeat  (btn_repeat[gi])
            );
        end
    endgenerate

    assign any_press = |btn_press;

endmodule
`default_nettype wire
